// File: rtl/lsu_bus_ctrl.sv
// Purpose: sequences one load/store request onto a single-ported 32-bit data bus, with lane alignment and load extension.
// Latency: request accepted at edge t; aligned access responds at t+3, a crossing access at t+5, a no-op or fault at t+1; bus stalls add cycle for cycle.
// Backpressure: o_req_ready is high only while idle; bus beats hold on i_bus_ready; o_rsp_valid is a pulse the consumer always takes.
//
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN
//   defined   - misaligned accesses execute; a word-crossing access runs two beats
//   undefined - any misaligned access faults at t+1 without touching the bus
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_*  request: op, byte address, right-justified store data
//   o_rsp_valid, o_rsp_rdata, o_rsp_fault  single-cycle completion
//   o_bus_valid/i_bus_ready, o_bus_*  beat request: word address, we, strobes, lane data
//   i_bus_rvalid, i_bus_rdata, i_bus_err   beat response

package lsu_pkg;
    typedef enum logic [3:0] {
        LSU_NOP     = 4'd0,
        LSU_LOAD_B  = 4'd1,
        LSU_LOAD_H  = 4'd2,
        LSU_LOAD_W  = 4'd3,
        LSU_LOAD_BU = 4'd4,
        LSU_LOAD_HU = 4'd5,
        LSU_STORE_B = 4'd6,
        LSU_STORE_H = 4'd7,
        LSU_STORE_W = 4'd8
    } lsu_ls_t;
endpackage

module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  lsu_ls_t               i_req_op,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_fault,
    output logic                  o_bus_valid,
    input  logic                  i_bus_ready,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic                  o_bus_we,
    output logic [3:0]            o_bus_wstrb,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    input  logic                  i_bus_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_BEAT0, S_WAIT0, S_BEAT1, S_WAIT1, S_DONE
    } state_t;

    state_t     state;
    lsu_ls_t    req_op;
    logic [1:0] req_off;
    logic [63:0] rbuf;

    // Access size in bytes; 0 marks a no-op encoding.
    function automatic logic [2:0] op_bytes(input lsu_ls_t op);
        case (op)
            LSU_LOAD_B, LSU_LOAD_BU, LSU_STORE_B: return 3'd1;
            LSU_LOAD_H, LSU_LOAD_HU, LSU_STORE_H: return 3'd2;
            LSU_LOAD_W, LSU_STORE_W:              return 3'd4;
            default:                              return 3'd0;
        endcase
    endfunction

    function automatic logic op_is_store(input lsu_ls_t op);
        return (op == LSU_STORE_B) || (op == LSU_STORE_H) || (op == LSU_STORE_W);
    endfunction

    // Stores, no-ops and anything not a load return zero.
    function automatic logic [31:0] load_extend(input lsu_ls_t op, input logic [31:0] raw);
        case (op)
            LSU_LOAD_B:  return {{24{raw[7]}}, raw[7:0]};
            LSU_LOAD_BU: return {24'd0, raw[7:0]};
            LSU_LOAD_H:  return {{16{raw[15]}}, raw[15:0]};
            LSU_LOAD_HU: return {16'd0, raw[15:0]};
            LSU_LOAD_W:  return raw;
            default:     return 32'd0;
        endcase
    endfunction

    logic [2:0] n_in;
    logic [1:0] off_in;
    logic [3:0] base_strb;
    logic       is_mem_in;
    logic       is_store_in;
    logic [3:0] lo_strb_in;
    logic [DATA_WIDTH-1:0] lo_data_in;

    assign n_in        = op_bytes(i_req_op);
    assign off_in      = i_req_addr[1:0];
    assign is_mem_in   = (n_in != 3'd0);
    assign is_store_in = op_is_store(i_req_op);
    assign base_strb   = (n_in == 3'd1) ? 4'b0001 :
                         (n_in == 3'd2) ? 4'b0011 : 4'b1111;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic [7:0]  m_in;
    logic [63:0] d_in;
    logic        cross_in;
    logic        req_cross;
    logic [3:0]  hi_strb;
    logic [DATA_WIDTH-1:0] hi_wdata;

    assign m_in       = {4'b0000, base_strb} << off_in;
    assign d_in       = {{DATA_WIDTH{1'b0}}, i_req_wdata} << {off_in, 3'b000};
    assign lo_strb_in = m_in[3:0];
    assign lo_data_in = d_in[31:0];
    assign cross_in   = ({2'b00, off_in} + {1'b0, n_in}) > 4'd4;
`else
    logic aligned_in;

    assign lo_strb_in = base_strb << off_in;
    assign lo_data_in = i_req_wdata << {off_in, 3'b000};
    assign aligned_in = (n_in == 3'd1) ||
                        ((n_in == 3'd2) && !off_in[0]) ||
                        ((n_in == 3'd4) && (off_in == 2'b00));
`endif

    // Buffer as it will look after the current read beat lands, so the
    // response can be extracted on the same edge that captures the data.
    logic [63:0] buf_nxt;
    logic [31:0] rd_ext;

    assign buf_nxt = (state == S_WAIT1) ? {i_bus_rdata, rbuf[31:0]}
                                        : {rbuf[63:32], i_bus_rdata};
    assign rd_ext  = load_extend(req_op, buf_nxt[{req_off, 3'b000} +: 32]);

    // Ready is forced low during reset so no request is taken while it is held.
    assign o_req_ready = (state == S_IDLE) && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            req_op      <= LSU_NOP;
            req_off     <= 2'b00;
            rbuf        <= 64'd0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_fault <= 1'b0;
            o_bus_valid <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_we    <= 1'b0;
            o_bus_wstrb <= 4'b0000;
            o_bus_wdata <= '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            req_cross   <= 1'b0;
            hi_strb     <= 4'b0000;
            hi_wdata    <= '0;
`endif
        end else begin
            o_rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        req_op  <= i_req_op;
                        req_off <= off_in;
                        if (!is_mem_in) begin
                            state       <= S_DONE;
                            o_rsp_valid <= 1'b1;
                        end
`ifndef LSU_MISALIGNED_SPLIT_EN
                        else if (!aligned_in) begin
                            state       <= S_DONE;
                            o_rsp_valid <= 1'b1;
                            o_rsp_fault <= 1'b1;
                        end
`endif
                        else begin
                            state       <= S_BEAT0;
                            o_bus_valid <= 1'b1;
                            o_bus_addr  <= {i_req_addr[ADDR_WIDTH-1:2], 2'b00};
                            o_bus_we    <= is_store_in;
                            o_bus_wstrb <= is_store_in ? lo_strb_in : 4'b0000;
                            o_bus_wdata <= is_store_in ? lo_data_in : '0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                            req_cross   <= cross_in;
                            hi_strb     <= is_store_in ? m_in[7:4] : 4'b0000;
                            hi_wdata    <= is_store_in ? d_in[63:32] : '0;
`endif
                        end
                    end
                end
                S_BEAT0: begin
                    if (i_bus_ready) begin
                        o_bus_valid <= 1'b0;
                        state       <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (i_bus_rvalid) begin
                        rbuf <= buf_nxt;
                        if (i_bus_err) begin
                            state       <= S_DONE;
                            o_rsp_valid <= 1'b1;
                            o_rsp_fault <= 1'b1;
                            o_rsp_rdata <= '0;
                        end
`ifdef LSU_MISALIGNED_SPLIT_EN
                        else if (req_cross) begin
                            state       <= S_BEAT1;
                            o_bus_valid <= 1'b1;
                            o_bus_addr  <= o_bus_addr + ADDR_WIDTH'(4);
                            o_bus_wstrb <= hi_strb;
                            o_bus_wdata <= hi_wdata;
                        end
`endif
                        else begin
                            state       <= S_DONE;
                            o_rsp_valid <= 1'b1;
                            o_rsp_rdata <= rd_ext;
                        end
                    end
                end
`ifdef LSU_MISALIGNED_SPLIT_EN
                S_BEAT1: begin
                    if (i_bus_ready) begin
                        o_bus_valid <= 1'b0;
                        state       <= S_WAIT1;
                    end
                end
                S_WAIT1: begin
                    if (i_bus_rvalid) begin
                        rbuf        <= buf_nxt;
                        state       <= S_DONE;
                        o_rsp_valid <= 1'b1;
                        o_rsp_fault <= i_bus_err;
                        o_rsp_rdata <= i_bus_err ? '0 : rd_ext;
                    end
                end
`endif
                S_DONE: begin
                    state       <= S_IDLE;
                    o_rsp_rdata <= '0;
                    o_rsp_fault <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;
    import lsu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    lsu_ls_t     i_req_op;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_fault;
    logic        o_bus_valid;
    logic        i_bus_ready;
    logic [31:0] o_bus_addr;
    logic        o_bus_we;
    logic [3:0]  o_bus_wstrb;
    logic [31:0] o_bus_wdata;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;
    logic        i_bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_bus_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_op     (i_req_op),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_fault  (o_rsp_fault),
        .o_bus_valid  (o_bus_valid),
        .i_bus_ready  (i_bus_ready),
        .o_bus_addr   (o_bus_addr),
        .o_bus_we     (o_bus_we),
        .o_bus_wstrb  (o_bus_wstrb),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata),
        .i_bus_err    (i_bus_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request against a bus that stalls ready for 'stall' cycles and then
    // answers in the cycle after the handshake; response checked at its exact cycle.
    task automatic run(input string tag, input lsu_ls_t op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] bus_rd, input logic err,
                       input int stall, input logic [31:0] e_addr, input logic [3:0] e_strb,
                       input logic [31:0] e_wdata, input logic e_we,
                       input logic [31:0] e_rdata, input logic e_fault);
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        chk({tag, ".req_ready"}, {31'd0, o_req_ready}, 32'd1);
        tick();
        i_req_valid = 1'b0;
        for (int k = 0; k < stall; k++) begin
            i_bus_ready = 1'b0;
            chk({tag, ".stall_valid"}, {31'd0, o_bus_valid}, 32'd1);
            chk({tag, ".stall_addr"}, o_bus_addr, e_addr);
            chk({tag, ".stall_wdata"}, e_we ? o_bus_wdata : 32'd0, e_we ? e_wdata : 32'd0);
            chk({tag, ".stall_rsp"}, {31'd0, o_rsp_valid}, 32'd0);
            tick();
        end
        i_bus_ready = 1'b1;
        chk({tag, ".bus_valid"}, {31'd0, o_bus_valid}, 32'd1);
        chk({tag, ".bus_addr"}, o_bus_addr, e_addr);
        chk({tag, ".bus_we"}, {31'd0, o_bus_we}, {31'd0, e_we});
        chk({tag, ".bus_wstrb"}, {28'd0, o_bus_wstrb}, {28'd0, e_strb});
        if (e_we) chk({tag, ".bus_wdata"}, o_bus_wdata, e_wdata);
        tick();
        chk({tag, ".valid_drop"}, {31'd0, o_bus_valid}, 32'd0);
        chk({tag, ".early_rsp"}, {31'd0, o_rsp_valid}, 32'd0);
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = bus_rd;
        i_bus_err    = err;
        tick();
        i_bus_rvalid = 1'b0;
        i_bus_err    = 1'b0;
        i_bus_rdata  = 32'd0;
        chk({tag, ".rsp_valid"}, {31'd0, o_rsp_valid}, 32'd1);
        chk({tag, ".rsp_rdata"}, o_rsp_rdata, e_rdata);
        chk({tag, ".rsp_fault"}, {31'd0, o_rsp_fault}, {31'd0, e_fault});
        tick();
        chk({tag, ".rsp_pulse"}, {31'd0, o_rsp_valid}, 32'd0);
    endtask

    // Request that must complete at t+1 with no bus beat.
    task automatic run_nobus(input string tag, input lsu_ls_t op, input logic [31:0] addr,
                             input logic e_fault);
        i_req_valid = 1'b1;
        i_req_op    = op;
        i_req_addr  = addr;
        i_req_wdata = 32'h1234_5678;
        tick();
        i_req_valid = 1'b0;
        chk({tag, ".rsp_valid"}, {31'd0, o_rsp_valid}, 32'd1);
        chk({tag, ".rsp_fault"}, {31'd0, o_rsp_fault}, {31'd0, e_fault});
        chk({tag, ".rsp_rdata"}, o_rsp_rdata, 32'd0);
        chk({tag, ".no_beat"}, {31'd0, o_bus_valid}, 32'd0);
        tick();
        chk({tag, ".no_beat2"}, {31'd0, o_bus_valid}, 32'd0);
        chk({tag, ".rsp_pulse"}, {31'd0, o_rsp_valid}, 32'd0);
    endtask

    initial begin
        i_rst        = 1'b1;
        i_req_valid  = 1'b1;
        i_req_op     = LSU_LOAD_W;
        i_req_addr   = 32'h0000_0000;
        i_req_wdata  = 32'd0;
        i_bus_ready  = 1'b1;
        i_bus_rvalid = 1'b0;
        i_bus_rdata  = 32'd0;
        i_bus_err    = 1'b0;

        // Reset held with a pending request: nothing may happen.
        tick();
        tick();
        chk("rst.req_ready", {31'd0, o_req_ready}, 32'd0);
        chk("rst.bus_valid", {31'd0, o_bus_valid}, 32'd0);
        chk("rst.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst.bus_addr", o_bus_addr, 32'd0);
        i_rst       = 1'b0;
        i_req_valid = 1'b0;
        #1;
        chk("rel.req_ready", {31'd0, o_req_ready}, 32'd1);
        chk("rel.bus_valid", {31'd0, o_bus_valid}, 32'd0);
        chk("rel.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        tick();

        // Stores: lane positioning.
        run("st_b", LSU_STORE_B, 32'h0000_1003, 32'h0000_00A5, 32'd0, 1'b0, 0,
            32'h0000_1000, 4'b1000, 32'hA500_0000, 1'b1, 32'd0, 1'b0);
        run("st_h", LSU_STORE_H, 32'h0000_1002, 32'h1234_BEEF, 32'd0, 1'b0, 0,
            32'h0000_1000, 4'b1100, 32'hBEEF_0000, 1'b1, 32'd0, 1'b0);
        run("st_w", LSU_STORE_W, 32'h0000_1004, 32'h1234_5678, 32'd0, 1'b0, 0,
            32'h0000_1004, 4'b1111, 32'h1234_5678, 1'b1, 32'd0, 1'b0);

        // Loads: extraction and extension.
        run("ld_h", LSU_LOAD_H, 32'h0000_2002, 32'd0, 32'h8001_1234, 1'b0, 0,
            32'h0000_2000, 4'b0000, 32'd0, 1'b0, 32'hFFFF_8001, 1'b0);
        run("ld_hu", LSU_LOAD_HU, 32'h0000_2002, 32'd0, 32'h8001_1234, 1'b0, 0,
            32'h0000_2000, 4'b0000, 32'd0, 1'b0, 32'h0000_8001, 1'b0);
        run("ld_b", LSU_LOAD_B, 32'h0000_2001, 32'd0, 32'h0000_F000, 1'b0, 0,
            32'h0000_2000, 4'b0000, 32'd0, 1'b0, 32'hFFFF_FFF0, 1'b0);
        run("ld_bu", LSU_LOAD_BU, 32'h0000_2003, 32'd0, 32'h7F00_0000, 1'b0, 0,
            32'h0000_2000, 4'b0000, 32'd0, 1'b0, 32'h0000_007F, 1'b0);
        run("ld_w", LSU_LOAD_W, 32'h0000_2000, 32'd0, 32'hDEAD_BEEF, 1'b0, 0,
            32'h0000_2000, 4'b0000, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // No-op encoding.
        run_nobus("nop", lsu_ls_t'(4'hF), 32'h0000_0100, 1'b0);

`ifdef LSU_MISALIGNED_SPLIT_EN
        // Word-crossing load split over two beats.
        i_req_valid = 1'b1;
        i_req_op    = LSU_LOAD_W;
        i_req_addr  = 32'h0000_3002;
        tick();
        i_req_valid = 1'b0;
        chk("split.b0_valid", {31'd0, o_bus_valid}, 32'd1);
        chk("split.b0_addr", o_bus_addr, 32'h0000_3000);
        tick();
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = 32'h4433_0000;
        tick();
        i_bus_rvalid = 1'b0;
        chk("split.b1_valid", {31'd0, o_bus_valid}, 32'd1);
        chk("split.b1_addr", o_bus_addr, 32'h0000_3004);
        chk("split.mid_rsp", {31'd0, o_rsp_valid}, 32'd0);
        tick();
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = 32'h0000_6655;
        tick();
        i_bus_rvalid = 1'b0;
        chk("split.rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
        chk("split.rsp_rdata", o_rsp_rdata, 32'h6655_4433);
        chk("split.rsp_fault", {31'd0, o_rsp_fault}, 32'd0);
        tick();
`else
        // Misaligned accesses fault immediately.
        run_nobus("mis_w", LSU_LOAD_W, 32'h0000_3002, 1'b1);
        run_nobus("mis_h", LSU_LOAD_H, 32'h0000_2001, 1'b1);
        run_nobus("mis_sw", LSU_STORE_W, 32'h0000_3001, 1'b1);
`endif

        // Stalled ready: response delayed exactly by the stall.
        run("stall", LSU_STORE_W, 32'h0000_4000, 32'hCAFE_F00D, 32'd0, 1'b0, 3,
            32'h0000_4000, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'd0, 1'b0);
        run("stall_err", LSU_STORE_W, 32'h0000_4000, 32'hCAFE_F00D, 32'd0, 1'b1, 3,
            32'h0000_4000, 4'b1111, 32'hCAFE_F00D, 1'b1, 32'd0, 1'b1);
        run("ld_err", LSU_LOAD_W, 32'h0000_4008, 32'd0, 32'h1111_2222, 1'b1, 0,
            32'h0000_4008, 4'b0000, 32'd0, 1'b0, 32'd0, 1'b1);

        // Reset during WAIT0, then a late response arriving in IDLE.
        i_req_valid = 1'b1;
        i_req_op    = LSU_LOAD_W;
        i_req_addr  = 32'h0000_5000;
        tick();
        i_req_valid = 1'b0;
        chk("abort.beat", {31'd0, o_bus_valid}, 32'd1);
        tick();
        i_rst = 1'b1;
        #1;
        chk("abort.rst_ready", {31'd0, o_req_ready}, 32'd0);
        tick();
        i_rst = 1'b0;
        chk("abort.bus_valid", {31'd0, o_bus_valid}, 32'd0);
        chk("abort.rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = 32'h5555_AAAA;
        tick();
        i_bus_rvalid = 1'b0;
        i_bus_rdata  = 32'd0;
        chk("abort.late_rsp", {31'd0, o_rsp_valid}, 32'd0);
        chk("abort.late_beat", {31'd0, o_bus_valid}, 32'd0);
        tick();
        chk("abort.late_rsp2", {31'd0, o_rsp_valid}, 32'd0);
        run("after_abort", LSU_LOAD_HU, 32'h0000_5006, 32'd0, 32'hABCD_0000, 1'b0, 0,
            32'h0000_5004, 4'b0000, 32'd0, 1'b0, 32'h0000_ABCD, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
